// File: rtl/stereo_frame_feeder.sv
// Stereo frame capture buffer: stores one left and one right camera frame,
// then serves 1-cycle-latency random reads until the consumer releases it.
module stereo_frame_feeder #(
   parameter int         WIDTH         = 19,
   parameter int         HEIGHT        = 6,
   parameter logic [7:0] DEFAULT_PIXEL = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       capture_enable,
   input  logic       cam_frame_start,
   input  logic       cam_valid,
   input  logic       cam_sel,
   input  logic [7:0] cam_data,
   input  logic       release_buffer,
   input  logic       rd_en,
   input  logic [9:0] rd_href,
   input  logic [9:0] rd_vref,
   input  logic       rd_sel,
   output logic [7:0] image_data,
   output logic       rd_valid,
   output logic       buffer_ready,
   output logic       overflow,
   output logic [1:0] state_LED
);

   localparam int CW = (WIDTH > 0) ? $clog2(WIDTH + 1) : 1;
   localparam int RW = (HEIGHT > 0) ? $clog2(HEIGHT + 1) : 1;
   localparam logic [CW-1:0] COL_MAX  = CW'(WIDTH);
   localparam logic [RW-1:0] ROW_MAX  = RW'(HEIGHT);
   localparam logic [9:0]    HREF_MAX = 10'(WIDTH);
   localparam logic [9:0]    VREF_MAX = 10'(HEIGHT);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ARMED   = 2'b01,
      CAPTURE = 2'b10,
      READY   = 2'b11
   } state_t;

   state_t state, state_nxt;

   logic [7:0] mem_l [0:WIDTH][0:HEIGHT];
   logic [7:0] mem_r [0:WIDTH][0:HEIGHT];

   logic [CW-1:0] lcol, rcol, lcol_nxt, rcol_nxt;
   logic [RW-1:0] lrow, rrow, lrow_nxt, rrow_nxt;
   logic          l_done, r_done, l_done_nxt, r_done_nxt;
   logic          l_wr, r_wr, l_ovf, r_ovf;
   logic          l_last, r_last;
   logic          cap_live, restart, arm;

   logic          rd_in_range;
   logic [CW-1:0] rd_col;
   logic [RW-1:0] rd_row;

   // A frame_start inside CAPTURE restarts and drops any pixel that cycle
   assign cap_live = (state == CAPTURE) && !cam_frame_start;
   assign restart  = (state == CAPTURE) && cam_frame_start;
   assign arm      = (state == IDLE) && capture_enable;

   assign l_last = (lcol == COL_MAX) && (lrow == ROW_MAX);
   assign r_last = (rcol == COL_MAX) && (rrow == ROW_MAX);

   assign l_wr  = cap_live && cam_valid && !cam_sel && !l_done;
   assign r_wr  = cap_live && cam_valid &&  cam_sel && !r_done;
   assign l_ovf = cap_live && cam_valid && !cam_sel &&  l_done;
   assign r_ovf = cap_live && cam_valid &&  cam_sel &&  r_done;

   assign l_done_nxt = l_done || (l_wr && l_last);
   assign r_done_nxt = r_done || (r_wr && r_last);

   assign state_LED = state;

   always_comb begin
      lcol_nxt = lcol;
      lrow_nxt = lrow;
      if (lcol < COL_MAX) begin
         lcol_nxt = lcol + CW'(1);
      end else if (lrow < ROW_MAX) begin
         lcol_nxt = '0;
         lrow_nxt = lrow + RW'(1);
      end
   end

   always_comb begin
      rcol_nxt = rcol;
      rrow_nxt = rrow;
      if (rcol < COL_MAX) begin
         rcol_nxt = rcol + CW'(1);
      end else if (rrow < ROW_MAX) begin
         rcol_nxt = '0;
         rrow_nxt = rrow + RW'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (capture_enable) state_nxt = ARMED;
         ARMED:   if (cam_frame_start) state_nxt = CAPTURE;
         CAPTURE: if (cap_live && l_done_nxt && r_done_nxt) state_nxt = READY;
         READY:   if (release_buffer) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         buffer_ready <= 1'b0;
         overflow     <= 1'b0;
         lcol         <= '0;
         lrow         <= '0;
         rcol         <= '0;
         rrow         <= '0;
         l_done       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         state        <= state_nxt;
         buffer_ready <= (state_nxt == READY);
         if (arm || restart) begin
            lcol   <= '0;
            lrow   <= '0;
            rcol   <= '0;
            rrow   <= '0;
            l_done <= 1'b0;
            r_done <= 1'b0;
            if (arm) overflow <= 1'b0;
         end else begin
            if (l_wr) begin
               lcol   <= lcol_nxt;
               lrow   <= lrow_nxt;
               l_done <= l_done_nxt;
            end
            if (r_wr) begin
               rcol   <= rcol_nxt;
               rrow   <= rrow_nxt;
               r_done <= r_done_nxt;
            end
            if (l_ovf || r_ovf) overflow <= 1'b1;
         end
      end
   end

   // Frame storage is never cleared; writes are suppressed while in reset
   always_ff @(posedge clk) begin
      if (!reset && l_wr) mem_l[lcol][lrow] <= cam_data;
   end

   always_ff @(posedge clk) begin
      if (!reset && r_wr) mem_r[rcol][rrow] <= cam_data;
   end

   assign rd_col      = rd_href[CW-1:0];
   assign rd_row      = rd_vref[RW-1:0];
   assign rd_in_range = (state == READY) &&
                        (rd_href <= HREF_MAX) &&
                        (rd_vref <= VREF_MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid   <= 1'b0;
         image_data <= DEFAULT_PIXEL;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            if (!rd_in_range)
               image_data <= DEFAULT_PIXEL;
            else if (rd_sel)
               image_data <= mem_r[rd_col][rd_row];
            else
               image_data <= mem_l[rd_col][rd_row];
         end
      end
   end

endmodule

// File: tb/tb_stereo_frame_feeder.sv
// Directed self-checking bench for stereo_frame_feeder.
// Frames are 20x7; pixel index = row*20 + col.
module tb_stereo_frame_feeder;

   logic       clk = 1'b0;
   logic       reset;
   logic       capture_enable;
   logic       cam_frame_start;
   logic       cam_valid;
   logic       cam_sel;
   logic [7:0] cam_data;
   logic       release_buffer;
   logic       rd_en;
   logic [9:0] rd_href;
   logic [9:0] rd_vref;
   logic       rd_sel;
   logic [7:0] image_data;
   logic       rd_valid;
   logic       buffer_ready;
   logic       overflow;
   logic [1:0] state_LED;

   int n_checks = 0;
   int n_fail   = 0;

   stereo_frame_feeder dut (
      .clk             (clk),
      .reset           (reset),
      .capture_enable  (capture_enable),
      .cam_frame_start (cam_frame_start),
      .cam_valid       (cam_valid),
      .cam_sel         (cam_sel),
      .cam_data        (cam_data),
      .release_buffer  (release_buffer),
      .rd_en           (rd_en),
      .rd_href         (rd_href),
      .rd_vref         (rd_vref),
      .rd_sel          (rd_sel),
      .image_data      (image_data),
      .rd_valid        (rd_valid),
      .buffer_ready    (buffer_ready),
      .overflow        (overflow),
      .state_LED       (state_LED)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pix(input logic sel, input logic [7:0] d);
      cam_valid = 1'b1;
      cam_sel   = sel;
      cam_data  = d;
      tick();
      cam_valid = 1'b0;
   endtask

   task automatic do_read(input int h, input int v, input logic s);
      rd_en   = 1'b1;
      rd_href = 10'(h);
      rd_vref = 10'(v);
      rd_sel  = s;
      tick();
      rd_en   = 1'b0;
   endtask

   task automatic arm_and_start();
      capture_enable = 1'b1;
      tick();
      capture_enable  = 1'b0;
      cam_frame_start = 1'b1;
      tick();
      cam_frame_start = 1'b0;
   endtask

   task automatic fill_sequential();
      for (int i = 0; i < 140; i++) send_pix(1'b0, 8'(i));
      for (int i = 0; i < 140; i++) send_pix(1'b1, 8'(255 - i));
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      n_checks++;
      if (state_LED !== 2'b00 || buffer_ready !== 1'b0 ||
          overflow !== 1'b0 || rd_valid !== 1'b0 || image_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset: state=%0d rdy=%b ovf=%b vld=%b data=%h, want 0 0 0 0 00",
                  state_LED, buffer_ready, overflow, rd_valid, image_data);
      end
   endtask

   task automatic test_sequential();
      arm_and_start();
      n_checks++;
      if (state_LED !== 2'b10) begin
         n_fail++;
         $display("FAIL seq_capture_state: got %0d want 2", state_LED);
      end
      for (int i = 0; i < 140; i++) send_pix(1'b0, 8'(i));
      for (int i = 0; i < 139; i++) send_pix(1'b1, 8'(255 - i));
      n_checks++;
      if (buffer_ready !== 1'b0 || state_LED !== 2'b10) begin
         n_fail++;
         $display("FAIL seq_pre_last: rdy=%b state=%0d want 0 2", buffer_ready, state_LED);
      end
      send_pix(1'b1, 8'(255 - 139));
      n_checks++;
      if (buffer_ready !== 1'b1 || state_LED !== 2'b11 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL seq_ready: rdy=%b state=%0d ovf=%b want 1 3 0",
                  buffer_ready, state_LED, overflow);
      end
   endtask

   task automatic test_read();
      do_read(5, 2, 1'b0);
      n_checks++;
      if (rd_valid !== 1'b1 || image_data !== 8'd45) begin
         n_fail++;
         $display("FAIL read_l_5_2: vld=%b data=%0d want 1 45", rd_valid, image_data);
      end
      do_read(5, 2, 1'b1);
      n_checks++;
      if (rd_valid !== 1'b1 || image_data !== 8'd210) begin
         n_fail++;
         $display("FAIL read_r_5_2: vld=%b data=%0d want 1 210", rd_valid, image_data);
      end
      tick();
      n_checks++;
      if (rd_valid !== 1'b0 || image_data !== 8'd210) begin
         n_fail++;
         $display("FAIL read_hold: vld=%b data=%0d want 0 210", rd_valid, image_data);
      end
      do_read(19, 6, 1'b0);
      n_checks++;
      if (image_data !== 8'd139) begin
         n_fail++;
         $display("FAIL read_l_corner: data=%0d want 139", image_data);
      end
      do_read(0, 0, 1'b1);
      n_checks++;
      if (image_data !== 8'd255) begin
         n_fail++;
         $display("FAIL read_r_origin: data=%0d want 255", image_data);
      end
      do_read(20, 0, 1'b0);
      n_checks++;
      if (rd_valid !== 1'b1 || image_data !== 8'h00) begin
         n_fail++;
         $display("FAIL read_href20: vld=%b data=%0d want 1 0", rd_valid, image_data);
      end
      do_read(3, 7, 1'b1);
      n_checks++;
      if (rd_valid !== 1'b1 || image_data !== 8'h00) begin
         n_fail++;
         $display("FAIL read_vref7: vld=%b data=%0d want 1 0", rd_valid, image_data);
      end
   endtask

   task automatic test_back_to_back();
      int exp [4];
      int hs [4];
      int vs [4];
      logic ss [4];
      hs = '{1, 19, 0, 10};
      vs = '{0, 6, 3, 1};
      ss = '{1'b0, 1'b1, 1'b0, 1'b1};
      exp = '{1, 116, 60, 225};
      for (int k = 0; k < 4; k++) begin
         rd_en   = 1'b1;
         rd_href = 10'(hs[k]);
         rd_vref = 10'(vs[k]);
         rd_sel  = ss[k];
         tick();
         n_checks++;
         if (rd_valid !== 1'b1 || image_data !== 8'(exp[k])) begin
            n_fail++;
            $display("FAIL b2b_%0d: vld=%b data=%0d want 1 %0d",
                     k, rd_valid, image_data, exp[k]);
         end
      end
      rd_en = 1'b0;
   endtask

   task automatic test_release();
      release_buffer = 1'b1;
      rd_en   = 1'b1;
      rd_href = 10'd5;
      rd_vref = 10'd2;
      rd_sel  = 1'b0;
      tick();
      release_buffer = 1'b0;
      rd_en = 1'b0;
      n_checks++;
      if (rd_valid !== 1'b1 || image_data !== 8'd45 ||
          buffer_ready !== 1'b0 || state_LED !== 2'b00) begin
         n_fail++;
         $display("FAIL release_read: vld=%b data=%0d rdy=%b state=%0d want 1 45 0 0",
                  rd_valid, image_data, buffer_ready, state_LED);
      end
      do_read(5, 2, 1'b0);
      n_checks++;
      if (image_data !== 8'h00) begin
         n_fail++;
         $display("FAIL read_idle: data=%0d want 0", image_data);
      end
   endtask

   task automatic test_interleave();
      arm_and_start();
      for (int i = 0; i < 140; i++) begin
         send_pix(1'b0, 8'(i));
         if (i % 3 == 0) tick();
         if (i == 70) begin
            do_read(5, 2, 1'b0);
            n_checks++;
            if (rd_valid !== 1'b1 || image_data !== 8'h00) begin
               n_fail++;
               $display("FAIL read_capture: vld=%b data=%0d want 1 0", rd_valid, image_data);
            end
         end
         if (i == 139) begin
            n_checks++;
            if (state_LED !== 2'b10 || buffer_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL il_pre_last: state=%0d rdy=%b want 2 0", state_LED, buffer_ready);
            end
         end
         send_pix(1'b1, 8'(255 - i));
      end
      n_checks++;
      if (state_LED !== 2'b11 || buffer_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL il_ready: state=%0d rdy=%b want 3 1", state_LED, buffer_ready);
      end
      do_read(5, 2, 1'b0);
      n_checks++;
      if (image_data !== 8'd45) begin
         n_fail++;
         $display("FAIL il_l_5_2: data=%0d want 45", image_data);
      end
      do_read(5, 2, 1'b1);
      n_checks++;
      if (image_data !== 8'd210) begin
         n_fail++;
         $display("FAIL il_r_5_2: data=%0d want 210", image_data);
      end
      do_read(19, 6, 1'b1);
      n_checks++;
      if (image_data !== 8'd116) begin
         n_fail++;
         $display("FAIL il_r_corner: data=%0d want 116", image_data);
      end
      release_buffer = 1'b1;
      tick();
      release_buffer = 1'b0;
   endtask

   task automatic test_overflow();
      arm_and_start();
      for (int i = 0; i < 140; i++) send_pix(1'b0, 8'(i));
      n_checks++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_full_no_ovf: got %b want 0", overflow);
      end
      for (int k = 0; k < 3; k++) send_pix(1'b0, 8'hAA);
      n_checks++;
      if (overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_set: got %b want 1", overflow);
      end
      for (int i = 0; i < 140; i++) send_pix(1'b1, 8'(255 - i));
      n_checks++;
      if (overflow !== 1'b1 || state_LED !== 2'b11) begin
         n_fail++;
         $display("FAIL ovf_sticky: ovf=%b state=%0d want 1 3", overflow, state_LED);
      end
      do_read(19, 6, 1'b0);
      n_checks++;
      if (image_data !== 8'd139) begin
         n_fail++;
         $display("FAIL ovf_corner: data=%0d want 139", image_data);
      end
      capture_enable = 1'b1;
      tick();
      n_checks++;
      if (state_LED !== 2'b11 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL enable_in_ready: state=%0d ovf=%b want 3 1", state_LED, overflow);
      end
      capture_enable = 1'b0;
      release_buffer = 1'b1;
      tick();
      release_buffer = 1'b0;
      n_checks++;
      if (overflow !== 1'b1 || state_LED !== 2'b00) begin
         n_fail++;
         $display("FAIL ovf_after_release: ovf=%b state=%0d want 1 0", overflow, state_LED);
      end
      capture_enable = 1'b1;
      tick();
      capture_enable = 1'b0;
      n_checks++;
      if (overflow !== 1'b0 || state_LED !== 2'b01) begin
         n_fail++;
         $display("FAIL ovf_clear: ovf=%b state=%0d want 0 1", overflow, state_LED);
      end
   endtask

   task automatic test_reset_mid_capture();
      cam_frame_start = 1'b1;
      tick();
      cam_frame_start = 1'b0;
      for (int i = 0; i < 50; i++) send_pix(1'b0, 8'h77);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if (state_LED !== 2'b00 || buffer_ready !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: state=%0d rdy=%b ovf=%b want 0 0 0",
                  state_LED, buffer_ready, overflow);
      end
      cam_frame_start = 1'b1;
      tick();
      cam_frame_start = 1'b0;
      for (int i = 0; i < 5; i++) send_pix(1'b0, 8'h55);
      n_checks++;
      if (state_LED !== 2'b00) begin
         n_fail++;
         $display("FAIL idle_ignores_cam: state=%0d want 0", state_LED);
      end
      arm_and_start();
      fill_sequential();
      n_checks++;
      if (state_LED !== 2'b11) begin
         n_fail++;
         $display("FAIL recapture_ready: state=%0d want 3", state_LED);
      end
      do_read(0, 0, 1'b0);
      n_checks++;
      if (image_data !== 8'd0) begin
         n_fail++;
         $display("FAIL recapture_origin: data=%0d want 0", image_data);
      end
      do_read(1, 0, 1'b0);
      n_checks++;
      if (image_data !== 8'd1) begin
         n_fail++;
         $display("FAIL recapture_1_0: data=%0d want 1", image_data);
      end
      do_read(9, 2, 1'b0);
      n_checks++;
      if (image_data !== 8'd49) begin
         n_fail++;
         $display("FAIL recapture_9_2: data=%0d want 49", image_data);
      end
   endtask

   initial begin
      reset           = 1'b1;
      capture_enable  = 1'b0;
      cam_frame_start = 1'b0;
      cam_valid       = 1'b0;
      cam_sel         = 1'b0;
      cam_data        = 8'h00;
      release_buffer  = 1'b0;
      rd_en           = 1'b0;
      rd_href         = '0;
      rd_vref         = '0;
      rd_sel          = 1'b0;
      test_reset();
      test_sequential();
      test_read();
      test_back_to_back();
      test_release();
      test_interleave();
      test_overflow();
      test_reset_mid_capture();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/stereo_frame_feeder.md
Name: stereo_frame_feeder

Overview:
Capture-side responder for the disparity engine's frame read interface. Accepts two 8-bit camera pixel streams (left/right), stores one frame of each in on-chip memory, and raises buffer_ready when both frames are complete. It then serves random-access reads addressed by href/vref/sel with fixed 1-cycle latency until the consumer releases the buffer.

Parameters:
WIDTH, 19, last column index (0-indexed; frame is WIDTH+1 pixels wide)
HEIGHT, 6, last row index (0-indexed; frame is HEIGHT+1 rows)
DEFAULT_PIXEL, 8'h00, value returned for out-of-range or non-READY reads

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
capture_enable  in  1  arm a new capture (level, sampled in IDLE)
cam_frame_start  in  1  1-cycle pulse marking the start of a stereo frame pair
cam_valid  in  1  cam_data valid this cycle
cam_sel  in  1  0 = left pixel, 1 = right pixel
cam_data  in  8  pixel value
release  in  1  consumer finished; return buffer to IDLE
rd_en  in  1  read request
rd_href  in  10  read column
rd_vref  in  10  read row
rd_sel  in  1  0 = left frame, 1 = right frame
image_data  out  8  read data (registered)
rd_valid  out  1  image_data valid (1 cycle after rd_en)
buffer_ready  out  1  both frames complete; reads are meaningful
overflow  out  1  sticky: pixels arrived beyond a full frame
state_LED  out  2  current state encoding

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high: on a clk edge with reset=1, all state clears. Reset values: state=IDLE, image_data=DEFAULT_PIXEL, rd_valid=0, buffer_ready=0, overflow=0, all write counters 0. Memory contents are not cleared.
- State encoding: IDLE=2'b00, ARMED=2'b01, CAPTURE=2'b10, READY=2'b11. state_LED = state.
- IDLE: when capture_enable=1, go to ARMED and clear overflow and all counters.
- ARMED: wait for cam_frame_start, then go to CAPTURE. cam_valid is ignored in ARMED.
- CAPTURE:
  - Two independent raster write pointers, (lcol,lrow) and (rcol,rrow); cam_sel picks which one advances.
  - A valid pixel writes mem_sel[col][row] <= cam_data.
  - Pointer update: if col<WIDTH, col+1; else if row<HEIGHT, col=0 and row+1; else the frame is full and the pointer holds.
  - A per-side done flag sets on the write to (WIDTH,HEIGHT).
  - A valid pixel for a side whose done flag is set is dropped and sets overflow.
  - When both done flags are set (including when the second one sets this cycle), go to READY on the next edge.
  - cam_frame_start in CAPTURE restarts capture: both pointers and done flags clear, and the state stays CAPTURE.
- READY:
  - buffer_ready=1 (registered, asserted the cycle the state is READY).
  - Camera inputs are ignored.
  - release=1 goes to IDLE, and buffer_ready drops on the same edge.
- Read port, active in all states:
  - rd_en=1 at edge N gives rd_valid=1 and image_data at edge N+1.
  - Data is mem_sel[rd_href][rd_vref] only if state==READY and rd_href<=WIDTH and rd_vref<=HEIGHT; otherwise DEFAULT_PIXEL.
  - rd_en=0 gives rd_valid=0, and image_data holds its last value.
  - Back-to-back reads every cycle are supported.
- Simultaneous events:
  - release and rd_en in the same cycle: the read is still served from READY data.
  - reset overrides everything.
  - capture_enable outside IDLE is ignored.
- Reset mid-CAPTURE: returns to IDLE. A new capture must see capture_enable and cam_frame_start again.
- Memory: two arrays of (WIDTH+1)*(HEIGHT+1) bytes, indexed [col][row], with a single write port and a single read port each.

Test Plan:
- Reset, then capture_enable=1, frame_start, then 140 left pixels (value = index mod 256) followed by 140 right pixels (value = 255-index) -> state READY. buffer_ready=1 exactly on the edge after pixel 280. overflow=0.
- From READY, rd_en with (href=5,vref=2,sel=0) -> one cycle later rd_valid=1, image_data=45. With sel=1 -> image_data=210.
- Interleave left/right pixels alternately with gaps in cam_valid -> same memory contents as the sequential case. READY reached after the last pixel of the later side.
- Send 3 extra left pixels after the left frame is full -> overflow=1 and sticky. Location (19,6) still holds 139. overflow clears on the next capture_enable from IDLE.
- Reads with href=20 or vref=7, and any read while in CAPTURE -> image_data=8'h00 with rd_valid=1.
- release in READY -> buffer_ready=0 and state IDLE next edge. Assert reset during CAPTURE at pixel 50 -> IDLE. Camera pixels then cause no writes until re-armed.
